conv_window_ctrl: RTL and testbench
===================================

# conv_window_ctrl

Sequencer that feeds the 3x3 convolution datapath from a pixel memory and writes its results to an output memory. It walks every valid 3x3 window (no padding) of an `IMG_WIDTH` x `IMG_HEIGHT` image in raster order. It reuses two columns between horizontally adjacent windows, so only the new column is fetched. The block presents each assembled window on `data_mat`, captures the datapath's combinational `w_data` and issues one write per window.

## Interface
- `IMG_WIDTH`, default 16: input image width in pixels; must be ≥ 3.
- `IMG_HEIGHT`, default 16: input image height in pixels; must be ≥ 3.
- `COLOUR_DEPTH`, default 8: pixel width.
- `ADDR_WIDTH`, default 8: read/write address width; must satisfy 2^`ADDR_WIDTH` ≥ `IMG_WIDTH`*`IMG_HEIGHT`.
- Kernel geometry is fixed at 3x3, so 9 window entries.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a frame; sampled only in IDLE.
- `busy` out 1: high in FILL/SHIFT/DRAIN/WRITE.
- `done` out 1: one-cycle pulse at frame end.
- `rd_en` out 1: pixel memory read strobe.
- `rd_addr` out `ADDR_WIDTH`: pixel address, (row*`IMG_WIDTH`)+col.
- `rd_data` in `COLOUR_DEPTH`: read data, valid exactly 1 cycle after `rd_en`.
- `data_mat` out 9 x `COLOUR_DEPTH`: window, index r*3+c (row r, column c, relative to top-left); index 4 is the centre.
- `mat_valid` out 1: `data_mat` is a complete window (WRITE state only).
- `w_data` in `COLOUR_DEPTH`: datapath result, combinational from `data_mat`.
- `wr_en` out 1: output memory write strobe.
- `wr_addr` out `ADDR_WIDTH`: y*(`IMG_WIDTH`-2)+x.
- `wr_data` out `COLOUR_DEPTH`: equals `w_data` while `wr_en` is high.

## Operation
Window origin counters: x in 0..`IMG_WIDTH`-3 and y in 0..`IMG_HEIGHT`-3. Read counter k.

States:
- **IDLE**
  - `start`=1 → FILL, with x=y=k=0.
  - `start` is ignored in every other state.
- **FILL**: full-window fetch at x=0.
  - Issues 9 reads over 9 consecutive cycles, k=0..8, column-major: c=k/3, r=k%3.
  - Read address is (y+r)*`IMG_WIDTH`+(x+c).
  - Leaves for DRAIN after k=8.
- **SHIFT**: fetch of the new column only.
  - On entry: col0←col1, col1←col2.
  - Issues 3 reads, r=0..2, at column x+2. Leaves for DRAIN after r=2.
- **DRAIN**
  - No read is issued; the last `rd_data` is captured.
  - Always → WRITE.
- **WRITE**
  - `mat_valid`=`wr_en`=1, `wr_data`=`w_data`, `wr_addr`=y*(`IMG_WIDTH`-2)+x.
  - Transitions:
    - x<`IMG_WIDTH`-3: x++ → SHIFT.
    - Else, y<`IMG_HEIGHT`-3: x=0, y++ → FILL.
    - Else → DONE.
- **DONE**
  - `done`=1 for one cycle, `busy`=0.
  - → IDLE.

Capture rules:
- Each `rd_data` is written to the window slot of the read issued one cycle earlier, using a registered slot index.
- Slot writes never occur in IDLE, DONE or WRITE.

Output rules:
- `rd_addr` = 0 when `rd_en`=0.
- `wr_addr` = 0 and `wr_data` = 0 when `wr_en`=0.
- `data_mat` holds its last value outside WRITE, but is meaningful only when `mat_valid`=1.
- No arithmetic is done on pixel data; counters wrap only through the explicit bound checks above.

## Timing
- Reset value of every output is 0: `busy`, `done`, `rd_en`, `rd_addr`, `data_mat` (all 9), `mat_valid`, `wr_en`, `wr_addr`, `wr_data`. State resets to IDLE and all counters clear.
- Latency:
  - First window of a row: 11 cycles (9 FILL + DRAIN + WRITE).
  - Subsequent windows: 5 cycles (3 SHIFT + DRAIN + WRITE).
- Frame length: (`IMG_HEIGHT`-2)*(11+5*(`IMG_WIDTH`-3)) cycles in FILL..WRITE.
  - Defaults: 14*76 = 1064.
  - With `start` sampled in cycle 0, `done` pulses in cycle 1065.
- Reset during any state:
  - All outputs are 0 and state is IDLE in the next cycle.
  - No further reads or writes occur.
  - A pending `rd_data` is discarded.
- `start` held high across DONE starts a new frame in the first IDLE cycle after DONE. No frame can start while `busy`=1.
- 3x3 image (`IMG_WIDTH`=`IMG_HEIGHT`=3): one FILL, one DRAIN, one WRITE, then DONE.

## Test plan
- **Ramp image**: pixel = address mod 256, defaults, `start` in cycle 0.
  - First WRITE (cycle 11): `data_mat` = {0,1,2,16,17,18,32,33,34}, `wr_addr`=0.
  - Second WRITE (cycle 16): `data_mat` = {1,2,3,17,18,19,33,34,35}, `wr_addr`=1.
- **Full frame, defaults**:
  - Exactly 196 `wr_en` pulses with `wr_addr` 0..195 in order.
  - `done` exactly in cycle 1065; `busy` high in cycles 1..1064.
- **Write data**: datapath model drives `w_data` = `data_mat[4]` → output memory equals the input interior, e.g. out[0]=17 and out[195]=238.
- **Start while busy**: `start` pulsed in cycle 50 → ignored; write count still 196, `done` still in cycle 1065.
- **Reset mid-operation**: `reset` high in cycle 300 → from cycle 301 all outputs are 0. A subsequent `start` gives a complete 196-write frame starting at `wr_addr` 0.
- **Minimum image**: `IMG_WIDTH`=`IMG_HEIGHT`=3 → 9 reads (addresses 0,3,6,1,4,7,2,5,8), one write at `wr_addr` 0 in cycle 11, `done` in cycle 12.

Source files
------------

// File: rtl/conv_window_ctrl.sv
// Sequencer for a 3x3 convolution datapath: walks every valid window of the image in raster
// order, fetching a full window at the start of each row and only the new column afterwards.
module conv_window_ctrl #(
    parameter int IMG_WIDTH    = 16,
    parameter int IMG_HEIGHT   = 16,
    parameter int COLOUR_DEPTH = 8,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         rd_en,
    output logic [ADDR_WIDTH-1:0]        rd_addr,
    input  logic [COLOUR_DEPTH-1:0]      rd_data,
    output logic [8:0][COLOUR_DEPTH-1:0] data_mat,
    output logic                         mat_valid,
    input  logic [COLOUR_DEPTH-1:0]      w_data,
    output logic                         wr_en,
    output logic [ADDR_WIDTH-1:0]        wr_addr,
    output logic [COLOUR_DEPTH-1:0]      wr_data,
    output logic [2:0]                   dbg_state_o
);

    // Handshake: no backpressure. A read issued with rd_en in cycle n returns on rd_data in
    // cycle n+1; a write is accepted in every cycle wr_en is high.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] X_LAST  = ADDR_WIDTH'(IMG_WIDTH - 3);
    localparam logic [ADDR_WIDTH-1:0] Y_LAST  = ADDR_WIDTH'(IMG_HEIGHT - 3);
    localparam logic [ADDR_WIDTH-1:0] RD_STEP = ADDR_WIDTH'(IMG_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] WR_STEP = ADDR_WIDTH'(IMG_WIDTH - 2);

    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [1:0] r_q, r_d, c_q, c_d;
    logic [3:0] slot_q, slot_d;
    logic cap_q;
    logic shift_win;
    logic [8:0][COLOUR_DEPTH-1:0] win_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_FILL;
            ST_FILL:  if (r_q == 2'd2 && c_q == 2'd2) state_d = ST_DRAIN;
            ST_SHIFT: if (r_q == 2'd2) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_WRITE;
            ST_WRITE: begin
                if (x_q < X_LAST)      state_d = ST_SHIFT;
                else if (y_q < Y_LAST) state_d = ST_FILL;
                else                   state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FILL walks the window column-major (r fastest); SHIFT pins c at the newest column.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        r_d       = r_q;
        c_d       = c_q;
        shift_win = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d = '0;
                    y_d = '0;
                    r_d = '0;
                    c_d = '0;
                end
            end
            ST_FILL: begin
                if (r_q == 2'd2) begin
                    r_d = 2'd0;
                    c_d = c_q + 2'd1;
                end else begin
                    r_d = r_q + 2'd1;
                end
            end
            ST_SHIFT: r_d = r_q + 2'd1;
            ST_WRITE: begin
                r_d = 2'd0;
                if (x_q < X_LAST) begin
                    x_d       = x_q + 1'b1;
                    c_d       = 2'd2;
                    shift_win = 1'b1;
                end else if (y_q < Y_LAST) begin
                    x_d = '0;
                    y_d = y_q + 1'b1;
                    c_d = 2'd0;
                end
            end
            default: ;
        endcase
    end

    assign slot_d = ({2'b00, r_q} * 4'd3) + {2'b00, c_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
            r_q <= '0;
            c_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            r_q <= r_d;
            c_q <= c_d;
        end
    end

    // Returning data lands in the slot remembered from the cycle the read was issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q  <= '0;
            cap_q  <= 1'b0;
            slot_q <= '0;
        end else begin
            cap_q  <= rd_en;
            slot_q <= slot_d;
            if (shift_win) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r*3]   <= win_q[r*3+1];
                    win_q[r*3+1] <= win_q[r*3+2];
                end
            end
            if (cap_q) begin
                win_q[slot_q] <= rd_data;
            end
        end
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        mat_valid = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        unique case (state_q)
            ST_FILL, ST_SHIFT: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = ((y_q + ADDR_WIDTH'(r_q)) * RD_STEP) + x_q + ADDR_WIDTH'(c_q);
            end
            ST_DRAIN: busy = 1'b1;
            ST_WRITE: begin
                busy      = 1'b1;
                mat_valid = 1'b1;
                wr_en     = 1'b1;
                wr_addr   = (y_q * WR_STEP) + x_q;
                wr_data   = w_data;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign data_mat    = win_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl: ramp-image frames on a 16x16 instance plus a 3x3 instance.
module tb_conv_window_ctrl;

  localparam int NWIN = 196;
  localparam int DONE_CYC = 1065;
  localparam int NO_RESET = 1_000_000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, busy, done, rd_en, mat_valid, wr_en;
  logic [7:0] rd_addr, rd_data, w_data, wr_addr, wr_data;
  logic [8:0][7:0] data_mat;
  logic [2:0] dbg_state;

  logic s_reset, s_start, s_busy, s_done, s_rd_en, s_mat_valid, s_wr_en;
  logic [7:0] s_rd_addr, s_rd_data, s_w_data, s_wr_addr, s_wr_data;
  logic [8:0][7:0] s_data_mat;
  logic [2:0] s_dbg_state;

  // Datapath model: passes the window centre through.
  assign w_data   = data_mat[4];
  assign s_w_data = s_data_mat[4];

  conv_window_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .data_mat(data_mat),
    .mat_valid(mat_valid), .w_data(w_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dbg_state_o(dbg_state)
  );

  conv_window_ctrl #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .COLOUR_DEPTH(8), .ADDR_WIDTH(8)) dut_s (
    .clk(clk), .reset(s_reset), .start(s_start), .busy(s_busy), .done(s_done),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .data_mat(s_data_mat),
    .mat_valid(s_mat_valid), .w_data(s_w_data), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .dbg_state_o(s_dbg_state)
  );

  typedef struct {
    int         cyc;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic       wr_en;
    logic [7:0] wr_addr;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] exp_q[$];
  logic [7:0] out_mem[256];
  int n_checks = 0;
  int n_fail = 0;
  int cur_cyc = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cur_cyc, act, exp);
    end
  endtask

  task automatic add_vec(input int c, input logic re, input logic [7:0] ra,
                         input logic we, input logic [7:0] wa);
    vec_t v;
    v.cyc = c; v.rd_en = re; v.rd_addr = ra; v.wr_en = we; v.wr_addr = wa;
    vecs.push_back(v);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 72'(busy), 72'(0));
    check({tag, "_done"}, 72'(done), 72'(0));
    check({tag, "_rd_en"}, 72'(rd_en), 72'(0));
    check({tag, "_rd_addr"}, 72'(rd_addr), 72'(0));
    check({tag, "_mat_valid"}, 72'(mat_valid), 72'(0));
    check({tag, "_wr_en"}, 72'(wr_en), 72'(0));
    check({tag, "_wr_addr"}, 72'(wr_addr), 72'(0));
    check({tag, "_wr_data"}, 72'(wr_data), 72'(0));
    check({tag, "_data_mat"}, 72'(data_mat), 72'(0));
    check({tag, "_state"}, 72'(dbg_state), 72'(0));
  endtask

  // One frame on the 16x16 instance; start in cycle 0, optional extra start and reset.
  task automatic run_frame(input int extra_start, input int reset_cyc, input int max_cyc,
                           input bit use_table);
    int writes;
    logic pend_en;
    logic [7:0] pend_addr;
    logic [8:0][7:0] ew;
    logic [7:0] a;
    int x, y;
    bit exp_busy;
    exp_q.delete();
    for (int i = 0; i < NWIN; i++) exp_q.push_back(8'(i));
    writes = 0;
    pend_en = 1'b0;
    pend_addr = '0;
    for (int cyc = 0; cyc <= max_cyc; cyc++) begin
      @(negedge clk);
      cur_cyc = cyc;
      rd_data = pend_en ? pend_addr : 8'd0;
      pend_en = rd_en;
      pend_addr = rd_addr;
      exp_busy = (cyc >= 1) && (cyc <= DONE_CYC - 1) && (cyc <= reset_cyc);
      check("busy", 72'(busy), 72'(exp_busy));
      check("done", 72'(done), 72'((cyc == DONE_CYC) && (reset_cyc > DONE_CYC)));
      check("mat_valid", 72'(mat_valid), 72'(wr_en));
      if (use_table) begin
        foreach (vecs[i]) begin
          if (vecs[i].cyc == cyc) begin
            check("tbl_rd_en", 72'(rd_en), 72'(vecs[i].rd_en));
            check("tbl_rd_addr", 72'(rd_addr), 72'(vecs[i].rd_addr));
            check("tbl_wr_en", 72'(wr_en), 72'(vecs[i].wr_en));
            check("tbl_wr_addr", 72'(wr_addr), 72'(vecs[i].wr_addr));
          end
        end
      end
      if (wr_en) begin
        writes++;
        out_mem[wr_addr] = wr_data;
        if (exp_q.size() == 0) begin
          check("extra_write", 72'(wr_addr), 72'(0));
        end else begin
          a = exp_q.pop_front();
          x = int'(a) % 14;
          y = int'(a) / 14;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              ew[r*3+c] = 8'((y + r) * 16 + x + c);
          check("wr_addr", 72'(wr_addr), 72'(a));
          check("window", 72'(data_mat), 72'(ew));
          check("wr_data", 72'(wr_data), 72'(ew[4]));
        end
      end
      if (cyc == reset_cyc + 1) check_quiet("post_reset");
      if (cyc > reset_cyc) check("quiet_after_reset", 72'({rd_en, wr_en}), 72'(0));
      start = (cyc == 0) || (cyc == extra_start);
      reset = (cyc == reset_cyc);
    end
    start = 1'b0;
    reset = 1'b0;
    if (reset_cyc > max_cyc) begin
      check("write_count", 72'(writes), 72'(NWIN));
      check("out_first", 72'(out_mem[0]), 72'(17));
      check("out_last", 72'(out_mem[195]), 72'(238));
    end
  endtask

  task automatic run_small();
    int addrs[9];
    logic pend_en;
    logic [7:0] pend_addr;
    addrs = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
    pend_en = 1'b0;
    pend_addr = '0;
    for (int cyc = 0; cyc <= 14; cyc++) begin
      @(negedge clk);
      cur_cyc = cyc;
      s_rd_data = pend_en ? pend_addr : 8'd0;
      pend_en = s_rd_en;
      pend_addr = s_rd_addr;
      if (cyc >= 1 && cyc <= 9) begin
        check("s_rd_en", 72'(s_rd_en), 72'(1));
        check("s_rd_addr", 72'(s_rd_addr), 72'(addrs[cyc-1]));
      end else begin
        check("s_rd_en", 72'(s_rd_en), 72'(0));
      end
      check("s_wr_en", 72'(s_wr_en), 72'(cyc == 11));
      check("s_done", 72'(s_done), 72'(cyc == 12));
      check("s_busy", 72'(s_busy), 72'(cyc >= 1 && cyc <= 11));
      if (cyc == 11) begin
        check("s_wr_addr", 72'(s_wr_addr), 72'(0));
        check("s_window", 72'(s_data_mat), 72'h08_07_06_05_04_03_02_01_00);
        check("s_wr_data", 72'(s_wr_data), 72'(4));
      end
      s_start = (cyc == 0);
    end
    s_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rd_data = '0;
    s_reset = 1'b1; s_start = 1'b0; s_rd_data = '0;
    for (int i = 0; i < 256; i++) out_mem[i] = '0;

    add_vec(0,    1'b0, 8'd0,  1'b0, 8'd0);
    add_vec(1,    1'b1, 8'd0,  1'b0, 8'd0);
    add_vec(2,    1'b1, 8'd16, 1'b0, 8'd0);
    add_vec(3,    1'b1, 8'd32, 1'b0, 8'd0);
    add_vec(4,    1'b1, 8'd1,  1'b0, 8'd0);
    add_vec(8,    1'b1, 8'd18, 1'b0, 8'd0);
    add_vec(9,    1'b1, 8'd34, 1'b0, 8'd0);
    add_vec(10,   1'b0, 8'd0,  1'b0, 8'd0);
    add_vec(11,   1'b0, 8'd0,  1'b1, 8'd0);
    add_vec(12,   1'b1, 8'd3,  1'b0, 8'd0);
    add_vec(13,   1'b1, 8'd19, 1'b0, 8'd0);
    add_vec(14,   1'b1, 8'd35, 1'b0, 8'd0);
    add_vec(15,   1'b0, 8'd0,  1'b0, 8'd0);
    add_vec(16,   1'b0, 8'd0,  1'b1, 8'd1);
    add_vec(17,   1'b1, 8'd4,  1'b0, 8'd0);
    add_vec(77,   1'b1, 8'd16, 1'b0, 8'd0);
    add_vec(87,   1'b0, 8'd0,  1'b1, 8'd14);
    add_vec(1064, 1'b0, 8'd0,  1'b1, 8'd195);
    add_vec(1065, 1'b0, 8'd0,  1'b0, 8'd0);

    // Clock/reset block
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
    s_reset = 1'b0;

    run_frame(50, NO_RESET, DONE_CYC + 2, 1'b1);
    run_frame(-1, 300, 320, 1'b0);
    for (int i = 0; i < 256; i++) out_mem[i] = '0;
    run_frame(-1, NO_RESET, DONE_CYC + 2, 1'b1);
    run_small();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
